x_pulse_tx: RTL and testbench

X_PULSE_TX -- requirements
Module: x_pulse_tx

---
 rtl/x_pulse_tx.sv | 126 ++++++++++++
 tb/tb_x_pulse_tx.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/x_pulse_tx.sv
// x_pulse_tx: emits bursts of single-cycle X pulses separated by a programmable
// number of idle cycles, and keeps a local mirror of the downstream counting
// receiver so the receiver's wrap indication can be predicted.
//
// Ports
//   Clock     in   single clock, all state updates on posedge
//   ResetN    in   synchronous active-low reset
//   ReqValid  in   burst request present
//   ReqReady  out  request can be accepted (IDLE only)
//   ReqCount  in   number of pulses in the burst, 0..2^CNT_W
//   ReqGap    in   number of X=0 cycles between consecutive pulses
//   X         out  registered serial pulse line
//   Busy      out  burst in progress (state != IDLE)
//   Done      out  one-cycle end-of-burst strobe
//   Mirror    out  count of X=1 cycles since reset, modulo 2^CNT_W
//   Wrap      out  combinational, high when Mirror is at its maximum value
module x_pulse_tx #(
    parameter int unsigned CNT_W = 3,
    parameter int unsigned GAP_W = 2
) (
    input  logic             Clock,
    input  logic             ResetN,
    input  logic             ReqValid,
    output logic             ReqReady,
    input  logic [CNT_W:0]   ReqCount,
    input  logic [GAP_W-1:0] ReqGap,
    output logic             X,
    output logic             Busy,
    output logic             Done,
    output logic [CNT_W-1:0] Mirror,
    output logic             Wrap
);

    localparam int unsigned REM_W = CNT_W + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PULSE = 2'd1,
        GAP   = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [REM_W-1:0]   remaining;
    logic [REM_W-1:0]   remaining_nxt;
    logic [GAP_W-1:0]   gap_lat;
    logic [GAP_W-1:0]   gap_lat_nxt;
    logic [GAP_W-1:0]   gap_cnt;
    logic [GAP_W-1:0]   gap_cnt_nxt;

    // Next-state and counter update logic
    always_comb begin
        state_nxt     = state;
        remaining_nxt = remaining;
        gap_lat_nxt   = gap_lat;
        gap_cnt_nxt   = gap_cnt;

        case (state)
            IDLE: begin
                if (ReqValid) begin
                    remaining_nxt = ReqCount;
                    gap_lat_nxt   = ReqGap;
                    state_nxt     = (ReqCount == REM_W'(0)) ? DONE : PULSE;
                end
            end
            PULSE: begin
                remaining_nxt = remaining - REM_W'(1);
                if (remaining == REM_W'(1)) begin
                    state_nxt = DONE;
                end else if (gap_lat == GAP_W'(0)) begin
                    state_nxt = PULSE;
                end else begin
                    state_nxt   = GAP;
                    gap_cnt_nxt = gap_lat;
                end
            end
            GAP: begin
                // Counter holds the number of gap cycles still to spend,
                // including the current one.
                gap_cnt_nxt = gap_cnt - GAP_W'(1);
                if (gap_cnt == GAP_W'(1)) begin
                    state_nxt = PULSE;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // State, counters and registered outputs
    always_ff @(posedge Clock) begin
        if (!ResetN) begin
            state     <= IDLE;
            remaining <= '0;
            gap_lat   <= '0;
            gap_cnt   <= '0;
            X         <= 1'b0;
            Busy      <= 1'b0;
            Done      <= 1'b0;
            ReqReady  <= 1'b1;
            Mirror    <= '0;
        end else begin
            state     <= state_nxt;
            remaining <= remaining_nxt;
            gap_lat   <= gap_lat_nxt;
            gap_cnt   <= gap_cnt_nxt;
            X         <= (state_nxt == PULSE);
            Busy      <= (state_nxt != IDLE);
            Done      <= (state_nxt == DONE);
            ReqReady  <= (state_nxt == IDLE);
            // Tracks the receiver, which counts X on this same edge.
            if (X) begin
                Mirror <= Mirror + CNT_W'(1);
            end
        end
    end

    // Receiver terminal-count prediction
    assign Wrap = (Mirror == {CNT_W{1'b1}});

endmodule

// File: tb/tb_x_pulse_tx.sv
// tb_x_pulse_tx: scoreboard bench for x_pulse_tx. Accepted requests are
// expanded into a per-cycle expected X/Done trace plus an end-of-burst record;
// a negedge monitor pops and compares. A counting receiver model driven by the
// expected X stream supplies the expected Mirror and Wrap values.
module tb_x_pulse_tx;

    localparam int unsigned CNT_W = 3;
    localparam int unsigned GAP_W = 2;
    localparam int          MOD   = 1 << CNT_W;

    logic             Clock = 1'b0;
    logic             ResetN = 1'b0;
    logic             ReqValid = 1'b0;
    logic             ReqReady;
    logic [CNT_W:0]   ReqCount = '0;
    logic [GAP_W-1:0] ReqGap = '0;
    logic             X;
    logic             Busy;
    logic             Done;
    logic [CNT_W-1:0] Mirror;
    logic             Wrap;

    x_pulse_tx #(.CNT_W(CNT_W), .GAP_W(GAP_W)) dut (
        .Clock    (Clock),
        .ResetN   (ResetN),
        .ReqValid (ReqValid),
        .ReqReady (ReqReady),
        .ReqCount (ReqCount),
        .ReqGap   (ReqGap),
        .X        (X),
        .Busy     (Busy),
        .Done     (Done),
        .Mirror   (Mirror),
        .Wrap     (Wrap)
    );

    always #5 Clock = ~Clock;

    typedef struct {
        int count;
        int mirror_end;
    } burst_t;

    int         checks = 0;
    int         passed = 0;
    logic [1:0] trace_q[$];     // per busy cycle: {x, done}
    burst_t     burst_q[$];
    int         rcv = 0;        // counting receiver model
    logic       exp_x = 1'b0;
    bit         armed = 1'b0;
    bit         model_idle = 1'b1;
    int         pulses_seen = 0;

    function automatic void check(input string name, input int act, input int exp);
        checks++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endfunction

    // Receiver: counts expected X on the same edge the DUT mirror does
    always @(posedge Clock) begin
        if (!ResetN) begin
            rcv   <= 0;
            armed <= 1'b1;
        end else if (exp_x) begin
            rcv <= (rcv + 1) % MOD;
        end
    end

    // Monitor: one trace entry per non-idle cycle, idle otherwise
    always @(negedge Clock) begin
        logic [1:0] e;
        burst_t     b;
        if (armed) begin
            if (trace_q.size() == 0) begin
                model_idle = 1'b1;
                exp_x      = 1'b0;
                check("idle_x", int'(X), 0);
                check("idle_done", int'(Done), 0);
                check("idle_busy", int'(Busy), 0);
                check("idle_ready", int'(ReqReady), 1);
            end else begin
                e          = trace_q.pop_front();
                model_idle = 1'b0;
                exp_x      = e[1];
                check("burst_x", int'(X), int'(e[1]));
                check("burst_done", int'(Done), int'(e[0]));
                check("burst_busy", int'(Busy), 1);
                check("burst_ready", int'(ReqReady), 0);
            end
            check("mirror", int'(Mirror), rcv);
            check("wrap", int'(Wrap), (rcv == MOD - 1) ? 1 : 0);
            if (X) pulses_seen++;
            if (Done) begin
                check("done_has_burst", (burst_q.size() > 0) ? 1 : 0, 1);
                if (burst_q.size() > 0) begin
                    b = burst_q.pop_front();
                    check("burst_pulse_total", pulses_seen, b.count);
                    check("burst_mirror_end", int'(Mirror), b.mirror_end);
                end
                pulses_seen = 0;
            end
        end
    end

    // Drive one cycle of inputs; predicts the burst if the request is accepted
    task automatic cycle(input bit rst, input bit v, input int cnt, input int gap);
        @(negedge Clock);
        #1;
        ResetN   = !rst;
        ReqValid = v;
        ReqCount = (CNT_W + 1)'(cnt);
        ReqGap   = GAP_W'(gap);
        if (rst) begin
            trace_q.delete();
            burst_q.delete();
            pulses_seen = 0;
        end else if (v && armed && model_idle) begin
            if (cnt == 0) begin
                trace_q.push_back(2'b01);
            end else begin
                for (int i = 0; i < cnt; i++) begin
                    trace_q.push_back(2'b10);
                    if (i < cnt - 1) repeat (gap) trace_q.push_back(2'b00);
                end
                trace_q.push_back(2'b01);
            end
            burst_q.push_back('{cnt, (rcv + cnt) % MOD});
            model_idle = 1'b0;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, $urandom_range(0, MOD), $urandom_range(0, 3));
    endtask

    initial begin
        cycle(1'b1, 1'b0, 0, 0);
        cycle(1'b1, 1'b0, 0, 0);
        // three back-to-back pulses
        cycle(1'b0, 1'b1, 3, 0);
        idle(6);
        // two pulses with a gap of two
        cycle(1'b0, 1'b1, 2, 2);
        idle(8);
        // Mirror is 5 here: wraps through 7 -> 0 and ends at 1
        cycle(1'b0, 1'b1, 4, 1);
        idle(12);
        // empty burst
        cycle(1'b0, 1'b1, 0, 0);
        idle(3);
        // full-range burst returns the mirror to its start value
        cycle(1'b0, 1'b1, MOD, 0);
        idle(12);
        // reset during the second pulse, then a fresh request
        cycle(1'b0, 1'b1, 5, 0);
        cycle(1'b0, 1'b0, 0, 0);
        cycle(1'b1, 1'b0, 0, 0);
        cycle(1'b0, 1'b1, 2, 0);
        idle(5);
        // valid held high with changing count while busy
        cycle(1'b0, 1'b1, 3, 1);
        for (int i = 0; i < 10; i++) cycle(1'b0, 1'b1, $urandom_range(0, MOD), $urandom_range(0, 3));
        idle(2);
        // randomized traffic with occasional resets
        for (int i = 0; i < 400; i++) begin
            cycle($urandom_range(0, 63) == 0, $urandom_range(0, 1) == 1,
                  $urandom_range(0, MOD), $urandom_range(0, 3));
        end
        for (int i = 0; i < 100 && trace_q.size() > 0; i++) cycle(1'b0, 1'b0, 0, 0);
        check("drain_trace_empty", trace_q.size(), 0);
        cycle(1'b0, 1'b0, 0, 0);
        cycle(1'b0, 1'b0, 0, 0);
        check("drain_bursts_empty", burst_q.size(), 0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
